// File: rtl/key_arbiter.sv
// Arrow-key make/break decoder with last-pressed arbitration and a frame tick.
// keycode only changes on frame boundaries so a move decision holds for a whole frame.
module key_arbiter #(
  parameter int unsigned TICK_DIV  = 1000000,
  parameter logic [7:0]  KEY_UP    = 8'h75,
  parameter logic [7:0]  KEY_DOWN  = 8'h72,
  parameter logic [7:0]  KEY_LEFT  = 8'h6B,
  parameter logic [7:0]  KEY_RIGHT = 8'h74
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       scan_valid,
  input  logic [7:0] scan_code,
  output logic [7:0] keycode,
  output logic       frame_tick,
  output logic [3:0] held
);

  localparam int CW = $clog2(TICK_DIV);
  localparam logic [CW-1:0] CNT_MAX = CW'(TICK_DIV - 1);

  typedef enum logic [1:0] {P_IDLE, P_EXT, P_EXT_BRK, P_BRK} pstate_t;

  pstate_t       state_reg, state_next;
  logic [CW-1:0] cnt_reg;
  logic [1:0]    last_idx_reg;
  logic          last_valid_reg;
  logic          key_hit, make, brk, wrap;
  logic [1:0]    key_idx;
  logic [3:0]    key_onehot, held_next;
  logic [7:0]    sel;

  // Index doubles as the bit position in held: 3=up, 2=left, 1=right, 0=down.
  function automatic logic [7:0] code_of(input logic [1:0] idx);
    case (idx)
      2'd3:    code_of = KEY_UP;
      2'd2:    code_of = KEY_LEFT;
      2'd1:    code_of = KEY_RIGHT;
      default: code_of = KEY_DOWN;
    endcase
  endfunction

  always_comb begin
    key_hit = 1'b1;
    key_idx = 2'd0;
    if (scan_code == KEY_UP)         key_idx = 2'd3;
    else if (scan_code == KEY_LEFT)  key_idx = 2'd2;
    else if (scan_code == KEY_RIGHT) key_idx = 2'd1;
    else if (scan_code == KEY_DOWN)  key_idx = 2'd0;
    else                             key_hit = 1'b0;
    key_onehot = 4'b0001 << key_idx;
  end

  always_comb begin
    state_next = state_reg;
    make       = 1'b0;
    brk        = 1'b0;
    if (scan_valid) begin
      case (state_reg)
        P_IDLE: begin
          if (scan_code == 8'hE0)      state_next = P_EXT;
          else if (scan_code == 8'hF0) state_next = P_BRK;
        end
        P_EXT: begin
          if (scan_code == 8'hF0)      state_next = P_EXT_BRK;
          else if (scan_code != 8'hE0) begin
            make       = key_hit;
            state_next = P_IDLE;
          end
        end
        P_EXT_BRK: begin
          brk        = key_hit;
          state_next = P_IDLE;
        end
        default: state_next = P_IDLE;
      endcase
    end
  end

  always_comb begin
    held_next = held;
    if (make) held_next = held | key_onehot;
    if (brk)  held_next = held & ~key_onehot;
  end

  always_comb begin
    sel = 8'h00;
    if (last_valid_reg) sel = code_of(last_idx_reg);
    else if (held[3])   sel = KEY_UP;
    else if (held[2])   sel = KEY_LEFT;
    else if (held[1])   sel = KEY_RIGHT;
    else if (held[0])   sel = KEY_DOWN;
  end

  assign wrap = (cnt_reg == CNT_MAX);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg      <= P_IDLE;
      held           <= 4'b0000;
      last_idx_reg   <= 2'd0;
      last_valid_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      held      <= held_next;
      // Typematic repeats of an already-held key must not steal priority.
      if (make && !held[key_idx]) begin
        last_idx_reg   <= key_idx;
        last_valid_reg <= 1'b1;
      end else if (brk && last_valid_reg && last_idx_reg == key_idx) begin
        last_valid_reg <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_reg    <= '0;
      frame_tick <= 1'b0;
      keycode    <= 8'h00;
    end else begin
      frame_tick <= wrap;
      if (wrap) begin
        cnt_reg <= '0;
        keycode <= sel;
      end else begin
        cnt_reg <= cnt_reg + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_key_arbiter.sv
// Bench for key_arbiter at TICK_DIV=4: expected keycodes are queued and
// compared by a monitor at each frame_tick.
module tb_key_arbiter;

  logic       clk = 1'b0;
  logic       rst;
  logic       scan_valid;
  logic [7:0] scan_code;
  logic [7:0] keycode;
  logic       frame_tick;
  logic [3:0] held;

  int vectors = 0;
  int miscompares = 0;
  logic [7:0] exp_q[$];

  key_arbiter #(.TICK_DIV(4)) dut (
    .clk(clk), .rst(rst), .scan_valid(scan_valid), .scan_code(scan_code),
    .keycode(keycode), .frame_tick(frame_tick), .held(held)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (!rst && frame_tick && exp_q.size() > 0) begin
      logic [7:0] e;
      e = exp_q.pop_front();
      vectors++;
      if (keycode !== e) begin
        miscompares++;
        $display("FAIL tick_keycode: got %h expected %h", keycode, e);
      end else
        $display("tick keycode=%h expected=%h ok", keycode, e);
    end
  end

  // Present one byte; the byte is accepted on the next rising edge.
  task automatic send(input logic [7:0] b);
    scan_valid = 1'b1;
    scan_code  = b;
    @(posedge clk); #1;
  endtask

  task automatic idle();
    scan_valid = 1'b0;
    scan_code  = 8'h00;
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 20 && exp_q.size() > 0; i++) @(posedge clk);
    #1;
    if (exp_q.size() != 0) begin
      vectors++;
      miscompares++;
      $display("FAIL tick_timeout: got no frame_tick required %0d pending", exp_q.size());
      exp_q.delete();
    end
  endtask

  // One settling edge guarantees every tick from here on reflects prior bytes.
  task automatic expect_key(input logic [7:0] code);
    @(posedge clk); #1;
    exp_q.push_back(code);
    wait_drain();
  endtask

  task automatic check_held(input string name, input logic [3:0] exp);
    vectors++;
    if (held !== exp) begin
      miscompares++;
      $display("FAIL %s: held got %b expected %b", name, held, exp);
    end else
      $display("%s held=%b ok", name, held);
  endtask

  task automatic test_reset();
    send(8'hE0); send(8'h75); idle();
    expect_key(8'h75);
    send(8'hE0); idle();
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    vectors += 3;
    if (keycode !== 8'h00) begin miscompares++; $display("FAIL reset_keycode: got %h expected 00", keycode); end
    if (held !== 4'b0000) begin miscompares++; $display("FAIL reset_held: got %b expected 0000", held); end
    if (frame_tick !== 1'b0) begin miscompares++; $display("FAIL reset_tick: got %b expected 0", frame_tick); end
    $display("reset applied keycode=%h held=%b frame_tick=%b", keycode, held, frame_tick);
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
    scan_valid = 1'b1;
    scan_code  = 8'h75;
    for (int k = 1; k <= 12; k++) begin
      @(posedge clk); #1;
      if (k == 1) idle();
      vectors++;
      if (frame_tick !== (k % 4 == 0)) begin
        miscompares++;
        $display("FAIL tick_period: cycle %0d got %b expected %b", k, frame_tick, (k % 4 == 0));
      end
    end
    check_held("reset_discards_partial", 4'b0000);
    vectors++;
    if (keycode !== 8'h00) begin miscompares++; $display("FAIL post_reset_keycode: got %h expected 00", keycode); end
  endtask

  task automatic test_single_key();
    send(8'hE0); send(8'h74); idle();
    check_held("single_make", 4'b0010);
    expect_key(8'h74);
    send(8'hE0); send(8'hF0); send(8'h74); idle();
    check_held("single_break", 4'b0000);
    expect_key(8'h00);
  endtask

  task automatic test_last_wins();
    send(8'hE0); send(8'h72); send(8'hE0); send(8'h6B); idle();
    check_held("down_left", 4'b0101);
    expect_key(8'h6B);
    send(8'hE0); send(8'hF0); send(8'h6B); idle();
    expect_key(8'h72);
    send(8'hE0); send(8'h75); send(8'hE0); send(8'h74);
    send(8'hE0); send(8'hF0); send(8'h74); idle();
    check_held("up_down", 4'b1001);
    expect_key(8'h75);
    send(8'hE0); send(8'hF0); send(8'h75);
    send(8'hE0); send(8'hF0); send(8'h72); idle();
    expect_key(8'h00);
  endtask

  task automatic test_typematic();
    send(8'hE0); send(8'h74); send(8'hE0); send(8'h6B);
    send(8'hE0); send(8'h74); idle();
    expect_key(8'h6B);
    send(8'hE0); send(8'hF0); send(8'h74); idle();
    expect_key(8'h6B);
    send(8'hE0); send(8'hF0); send(8'h6B); idle();
    expect_key(8'h00);
  endtask

  task automatic test_noise();
    send(8'hF0); send(8'h75); send(8'h75); send(8'hE0); send(8'h12); idle();
    check_held("noise", 4'b0000);
    expect_key(8'h00);
    send(8'hE0); send(8'hE0); send(8'h75); idle();
    check_held("double_e0", 4'b1000);
    expect_key(8'h75);
    send(8'hE0); send(8'hF0); send(8'h75); idle();
    expect_key(8'h00);
  endtask

  task automatic test_frame_align();
    bit seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(posedge clk); #1;
      if (frame_tick) seen = 1'b1;
    end
    vectors++;
    if (!seen) begin
      miscompares++;
      $display("FAIL align_sync: got no frame_tick required one within 20 cycles");
    end
    @(posedge clk); #1;
    @(posedge clk); #1;
    send(8'hE0); send(8'h75); idle();
    vectors += 2;
    if (frame_tick !== 1'b1) begin miscompares++; $display("FAIL align_tick: got %b expected 1", frame_tick); end
    if (keycode !== 8'h00) begin miscompares++; $display("FAIL align_stale: got %h expected 00", keycode); end
    $display("align wrap-edge byte tick=%b keycode=%h", frame_tick, keycode);
    expect_key(8'h75);
    send(8'hE0); send(8'hF0); send(8'h75); idle();
    expect_key(8'h00);
  endtask

  initial begin
    rst = 1'b1;
    scan_valid = 1'b0;
    scan_code = 8'h00;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    test_reset();
    test_single_key();
    test_last_wins();
    test_typematic();
    test_noise();
    test_frame_align();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
